ula_seq: RTL and testbench

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_seq_if.sv | 27 ++
 rtl/ula_seq.sv | 174 +++++++++++++++++
 tb/tb_ula_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_seq_if.sv
// Request/result bundle for ula_seq: operands and opcode in, registered results,
// flags and busy/done handshake out.
interface ula_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ALUOut;
  logic [WIDTH-1:0] Hi;
  logic             Zero;
  logic             Overflow;
  logic             DivZero;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUctl, A, B,
    input  ALUOut, Hi, Zero, Overflow, DivZero, busy, done
  );

  modport slave (
    input  start, ALUctl, A, B,
    output ALUOut, Hi, Zero, Overflow, DivZero, busy, done
  );
endinterface

// File: rtl/ula_seq.sv
// Sequential ALU: logic/arithmetic ops finish in one edge, MULT (shift-add) and
// DIVU (restoring) take WIDTH iterations and share one datapath register pair.
module ula_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  ula_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] p_hi_reg;    // MULT: partial product high / DIVU: remainder
  logic [WIDTH-1:0] p_lo_reg;    // MULT: multiplier shifting out / DIVU: dividend -> quotient
  logic [WIDTH-1:0] mcand_reg;   // multiplicand or divisor
  logic [WIDTH-1:0] alu_out_reg;
  logic [WIDTH-1:0] hi_reg;
  logic             zero_reg;
  logic             ovf_reg;
  logic             dz_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  always_comb begin
    add_sum = {1'b0, p_hi_reg} + (p_lo_reg[0] ? {1'b0, mcand_reg} : '0);
    shifted = {p_hi_reg, p_lo_reg[WIDTH-1]};
    trial   = shifted - {1'b0, mcand_reg};
    iter_hi = '0;
    iter_lo = '0;
    if (state_reg == MUL) begin
      iter_hi = add_sum[WIDTH:1];
      iter_lo = {add_sum[0], p_lo_reg[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      iter_hi = trial[WIDTH-1:0];
      iter_lo = {p_lo_reg[WIDTH-2:0], 1'b1};
    end else begin
      iter_hi = shifted[WIDTH-1:0];
      iter_lo = {p_lo_reg[WIDTH-2:0], 1'b0};
    end
  end

  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] dif_ab;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] single_hi;
  logic             single_zero;
  logic             single_ovf;
  logic             single_dz;

  // Single-edge results; DIVU only lands here when the divisor is zero.
  always_comb begin
    sum_ab      = bus.A + bus.B;
    dif_ab      = bus.A - bus.B;
    single_res  = '0;
    single_hi   = '0;
    single_ovf  = 1'b0;
    single_dz   = 1'b0;
    single_zero = 1'b0;
    case (bus.ALUctl)
      OP_AND: single_res = bus.A & bus.B;
      OP_OR:  single_res = bus.A | bus.B;
      OP_NOR: single_res = ~(bus.A | bus.B);
      OP_SLT: single_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_ADD: begin
        single_res = sum_ab;
        single_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_ab[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        single_res = dif_ab;
        single_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif_ab[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_DIVU: begin
        single_res = '1;
        single_hi  = bus.A;
        single_dz  = 1'b1;
      end
      default: ;
    endcase
    case (bus.ALUctl)
      OP_AND, OP_OR, OP_NOR, OP_SLT, OP_ADD, OP_SUB, OP_DIVU: single_zero = (single_res == '0);
      default: single_zero = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      p_hi_reg    <= '0;
      p_lo_reg    <= '0;
      mcand_reg   <= '0;
      alu_out_reg <= '0;
      hi_reg      <= '0;
      zero_reg    <= 1'b1;
      ovf_reg     <= 1'b0;
      dz_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, FIN: begin
          state_reg <= IDLE;
          if (bus.start) begin
            if (bus.ALUctl == OP_MULT) begin
              p_hi_reg  <= '0;
              p_lo_reg  <= bus.B;
              mcand_reg <= bus.A;
              cnt_reg   <= CW'(WIDTH);
              busy_reg  <= 1'b1;
              state_reg <= MUL;
            end else if (bus.ALUctl == OP_DIVU && bus.B != '0) begin
              p_hi_reg  <= '0;
              p_lo_reg  <= bus.A;
              mcand_reg <= bus.B;
              cnt_reg   <= CW'(WIDTH);
              busy_reg  <= 1'b1;
              state_reg <= DIV;
            end else begin
              alu_out_reg <= single_res;
              hi_reg      <= single_hi;
              zero_reg    <= single_zero;
              ovf_reg     <= single_ovf;
              dz_reg      <= single_dz;
              done_reg    <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          p_hi_reg <= iter_hi;
          p_lo_reg <= iter_lo;
          cnt_reg  <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            alu_out_reg <= iter_lo;
            hi_reg      <= iter_hi;
            zero_reg    <= (iter_lo == '0);
            ovf_reg     <= 1'b0;
            dz_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= FIN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ALUOut   = alu_out_reg;
  assign bus.Hi       = hi_reg;
  assign bus.Zero     = zero_reg;
  assign bus.Overflow = ovf_reg;
  assign bus.DivZero  = dz_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: expected results are queued at issue and
// popped when done is seen.
module tb_ula_seq;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         o;
    logic         d;
  } res_t;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int unsigned cyc;
  res_t exp_q[$];

  ula_seq_if #(.WIDTH(W)) bus ();

  ula_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t        m;
    longint      s;
    logic [63:0] p;
    m = '0;
    case (op)
      4'd0:  m.res = a & b;
      4'd1:  m.res = a | b;
      4'd12: m.res = ~(a | b);
      4'd7:  m.res = (a < b) ? 32'd1 : 32'd0;
      4'd2: begin
        s = longint'($signed(a)) + longint'($signed(b));
        m.res = s[31:0];
        m.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        s = longint'($signed(a)) - longint'($signed(b));
        m.res = s[31:0];
        m.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd8: begin
        p = 64'(a) * 64'(b);
        m.res = p[31:0];
        m.hi  = p[63:32];
      end
      4'd9: begin
        if (b == 0) begin
          m.res = 32'hFFFF_FFFF;
          m.hi  = a;
          m.d   = 1'b1;
        end else begin
          m.res = a / b;
          m.hi  = a % b;
        end
      end
      default: m = '0;
    endcase
    if (op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12}) m.z = (m.res == 0);
    return m;
  endfunction

  function automatic res_t got();
    return {bus.ALUOut, bus.Hi, bus.Zero, bus.Overflow, bus.DivZero};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
    @(negedge clock);
    bus.start = 1'b1; bus.ALUctl = op; bus.A = a; bus.B = b;
    if (accept) exp_q.push_back(model(op, a, b));
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Returns cycles after the accepting edge until done is seen (-1 on timeout).
  task automatic wait_done(input int budget, output int lat, output int busy_n, output bit moved);
    logic [W-1:0] r0, h0;
    r0 = bus.ALUOut; h0 = bus.Hi;
    lat = -1; busy_n = 0; moved = 1'b0;
    for (int n = 0; n <= budget; n++) begin
      if (n > 0) begin @(posedge clock); #1; end
      if (bus.busy) busy_n++;
      if (bus.done) begin lat = n; break; end
      if (bus.ALUOut !== r0 || bus.Hi !== h0) moved = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [6+2*W-1:0] g, e;
    reset_n = 1'b0; bus.start = 1'b0; bus.ALUctl = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clock);
    #1;
    g = {bus.ALUOut, bus.Hi, bus.Zero, bus.Overflow, bus.DivZero, bus.busy, bus.done, 1'b0};
    e = {32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (g !== e) begin n_bad++; $display("FAIL reset: got %h required %h", g, e); end
    else $display("txn reset outputs=%h", g);
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    int lat, bn; bit mv; res_t e;
    issue(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b1);
    wait_done(5, lat, bn, mv);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 0 || bn !== 0) begin n_bad++; $display("FAIL add_timing: lat %0d busy %0d required 0/0", lat, bn); end
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL add_ovf: got %h required %h", got(), e); end
    else $display("txn add_ovf result=%h", got());
    @(posedge clock); #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse: done %b required 0", bus.done); end
  endtask

  task automatic test_mult_max();
    int lat, bn; bit mv; res_t e;
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    bus.A = $urandom; bus.B = $urandom;
    wait_done(40, lat, bn, mv);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 32 || bn !== 32) begin n_bad++; $display("FAIL mult_timing: lat %0d busy %0d required 32/32", lat, bn); end
    n_cmp++;
    if (mv !== 1'b0) begin n_bad++; $display("FAIL mult_hold: outputs moved %b required 0", mv); end
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL mult_max: got %h required %h", got(), e); end
    else $display("txn mult_max lat=%0d result=%h", lat, got());
  endtask

  task automatic test_divu_ignore();
    int lat, bn, extra; bit mv; res_t e; int unsigned k;
    issue(4'd9, 32'd100, 32'd7, 1'b1);
    k = cyc;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.start = 1'b1; bus.ALUctl = 4'd2; bus.A = 32'd1; bus.B = 32'd1;
    @(posedge clock); #1; bus.start = 1'b0;
    wait_done(40, lat, bn, mv);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat < 0 || (cyc - k) !== 32) begin n_bad++; $display("FAIL divu_timing: lat %0d span %0d required 32", lat, cyc - k); end
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL divu: got %h required %h", got(), e); end
    else $display("txn divu span=%0d result=%h", cyc - k, got());
    extra = 0;
    repeat (40) begin @(posedge clock); #1; if (bus.done) extra++; end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL divu_no_extra: extra done %0d required 0", extra); end
  endtask

  task automatic test_divzero();
    int lat, bn; bit mv; res_t e;
    issue(4'd9, 32'd5, 32'd0, 1'b1);
    wait_done(5, lat, bn, mv);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 0) begin n_bad++; $display("FAIL divzero_timing: lat %0d required 0", lat); end
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL divzero: got %h required %h", got(), e); end
    else $display("txn divzero result=%h", got());
  endtask

  task automatic test_reset_mid_mult();
    logic [6+2*W-1:0] g, ex; res_t e; int extra;
    issue(4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (9) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    g  = {bus.ALUOut, bus.Hi, bus.Zero, bus.Overflow, bus.DivZero, bus.busy, bus.done, 1'b0};
    ex = {32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (g !== ex) begin n_bad++; $display("FAIL reset_mid: got %h required %h", g, ex); end
    else $display("txn reset_mid outputs=%h", g);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    bus.start = 1'b1; bus.ALUctl = 4'd6; bus.A = 32'd3; bus.B = 32'd3;
    exp_q.push_back(model(4'd6, 32'd3, 32'd3));
    @(posedge clock); #1; bus.start = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.done !== 1'b1 || got() !== e) begin
      n_bad++; $display("FAIL sub_after_reset: done %b got %h required 1 %h", bus.done, got(), e);
    end else $display("txn sub_after_reset result=%h", got());
    extra = 0;
    repeat (40) begin @(posedge clock); #1; if (bus.done) extra++; end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL reset_no_done: stray done %0d required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit mv; res_t e; int unsigned t1, t2;
    issue(4'd8, 32'd3, 32'd4, 1'b1);
    wait_done(40, lat, bn, mv);
    t1 = cyc;
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 32 || got() !== e) begin n_bad++; $display("FAIL b2b_first: lat %0d got %h required 32 %h", lat, got(), e); end
    else $display("txn b2b_first result=%h", got());
    issue(4'd8, 32'd3, 32'd4, 1'b1);
    wait_done(40, lat, bn, mv);
    t2 = cyc;
    e = exp_q.pop_front();
    n_cmp++;
    if (lat < 0 || (t2 - t1) !== 33) begin n_bad++; $display("FAIL b2b_gap: gap %0d required 33", t2 - t1); end
    n_cmp++;
    if (got() !== e) begin n_bad++; $display("FAIL b2b_second: got %h required %h", got(), e); end
    else $display("txn b2b_second gap=%0d result=%h", t2 - t1, got());
    issue(4'd5, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    wait_done(5, lat, bn, mv);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 0 || got() !== e) begin n_bad++; $display("FAIL illegal_op: lat %0d got %h required 0 %h", lat, got(), e); end
    else $display("txn illegal_op result=%h", got());
  endtask

  task automatic test_random();
    logic [3:0] ops [9];
    logic [3:0] op; logic [W-1:0] a, b;
    int lat, bn, want; bit mv; res_t e;
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd3};
    for (int i = 0; i < 16; i++) begin
      op = ops[$urandom_range(0, 8)];
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      want = (op == 4'd8 || (op == 4'd9 && b != 0)) ? 32 : 0;
      issue(op, a, b, 1'b1);
      if (want != 0) begin bus.A = $urandom; bus.B = $urandom; end
      wait_done(40, lat, bn, mv);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== want || got() !== e) begin
        n_bad++; $display("FAIL rand_%0d: op %0d lat %0d got %h required %0d %h", i, op, lat, got(), want, e);
      end else $display("txn rand_%0d op=%0d a=%h b=%h result=%h", i, op, a, b, got());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    test_reset();
    test_add_overflow();
    test_mult_max();
    test_divu_ignore();
    test_divzero();
    test_reset_mid_mult();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
